// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param. The master drives the addresses, write
// controls and clear request. The slave returns read data and status.
interface reg_file_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [1:0]        reg_write;
    logic [DATA_W-1:0] wr_data;
    logic              clr_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] reg_val1;
    logic [DATA_W-1:0] reg_val2;
    logic [DATA_W-1:0] dbg_data;
    logic              clr_busy;
    logic              wr_drop;

    modport master (
        output rs, rt, reg_write, wr_data, clr_req, dbg_addr,
        input  reg_val1, reg_val2, dbg_data, clr_busy, wr_drop
    );

    modport slave (
        input  rs, rt, reg_write, wr_data, clr_req, dbg_addr,
        output reg_val1, reg_val2, dbg_data, clr_busy, wr_drop
    );
endinterface

// File: rtl/reg_file_param.sv
// KGP-miniRISC register file: two combinational read ports, one write port with
// rs/rt/link destinations, optional write-through bypass, sequenced clear and debug read.
module reg_file_param #(
    parameter int                DATA_W   = 32,
    parameter int                NUM_REGS = 32,
    parameter int                ADDR_W   = 5,
    parameter int                LINK_REG = 31,
    parameter int                BYPASS   = 1,
    parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    reg_file_param_if.slave  bus
);

    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LINK_ADDR  = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
    localparam bit                BYP_ON     = (BYPASS != 0);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] wr_dest;
    logic              wr_req, wr_en, drop, byp_en, wr_drop_q;
    logic              rs_ok, rt_ok, dbg_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NUM_REGS_W;
    endfunction

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        wr_dest = LINK_ADDR;
        case (bus.reg_write)
            2'b01:   wr_dest = bus.rs;
            2'b10:   wr_dest = bus.rt;
            default: wr_dest = LINK_ADDR;
        endcase
    end

    // Writes only land in IDLE and in range; anything else is reported as dropped.
    assign wr_req = (bus.reg_write != 2'b00);
    assign wr_en  = wr_req && (state == IDLE) && in_range(wr_dest);
    assign drop   = wr_req && !wr_en;
    assign byp_en = BYP_ON && wr_en;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.clr_req) state_nxt = CLEAR;
            CLEAR:   if (cnt == LAST_ADDR) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_drop_q <= drop;
            if (state == IDLE && bus.clr_req)
                cnt <= '0;
            else if (state == CLEAR)
                cnt <= cnt + 1'b1;
        end
    end

    // NOTE: the array is reset explicitly; reset must clear it, so it stays flop-based rather than a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= RST_VAL;
        end else if (state == CLEAR) begin
            regs[cnt] <= RST_VAL;
        end else if (wr_en) begin
            regs[wr_dest] <= wr_data_q();
        end
    end

    function automatic logic [DATA_W-1:0] wr_data_q();
        return bus.wr_data;
    endfunction

    assign rs_ok  = in_range(bus.rs);
    assign rt_ok  = in_range(bus.rt);
    assign dbg_ok = in_range(bus.dbg_addr);

    assign bus.reg_val1 = (byp_en && bus.rs == wr_dest) ? bus.wr_data :
                          rs_ok ? regs[bus.rs] : '0;
    assign bus.reg_val2 = (byp_en && bus.rt == wr_dest) ? bus.wr_data :
                          rt_ok ? regs[bus.rt] : '0;
    // Debug port always shows the stored array, never the in-flight write.
    assign bus.dbg_data = dbg_ok ? regs[bus.dbg_addr] : '0;

    assign bus.clr_busy = (state == CLEAR);
    assign bus.wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: main instance with defaults plus a
// 24-register, no-bypass instance for range and bypass-off behaviour.
module tb_reg_file_param;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    reg_file_param_if #(.DATA_W(32), .ADDR_W(5)) bus  ();
    reg_file_param_if #(.DATA_W(32), .ADDR_W(5)) bus2 ();

    reg_file_param #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .LINK_REG(31), .BYPASS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    reg_file_param #(.DATA_W(32), .NUM_REGS(24), .ADDR_W(5), .LINK_REG(20), .BYPASS(0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rs = '0;  bus.rt = '0;  bus.reg_write = 2'b00; bus.wr_data = '0;
        bus.clr_req = 1'b0; bus.dbg_addr = '0;
        bus2.rs = '0; bus2.rt = '0; bus2.reg_write = 2'b00; bus2.wr_data = '0;
        bus2.clr_req = 1'b0; bus2.dbg_addr = '0;
    endtask

    task automatic fill_main(input int mul, input int add);
        for (int i = 0; i < 32; i++) begin
            bus.rs = 5'(i);
            bus.reg_write = 2'b01;
            bus.wr_data = 32'(i * mul + add);
            tick();
        end
        bus.reg_write = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (3) tick();
        checks++;
        if (bus.clr_busy !== 1'b0) begin
            errors++; $display("FAIL reset_clr_busy: got %b expected 0", bus.clr_busy);
        end
        rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            bus.rs = 5'(a); bus.rt = 5'(a); bus.dbg_addr = 5'(a);
            #1;
            checks++;
            if (bus.reg_val1 !== 32'd0 || bus.reg_val2 !== 32'd0 || bus.dbg_data !== 32'd0) begin
                errors++;
                $display("FAIL reset_read a=%0d: got %h/%h/%h expected 0/0/0",
                         a, bus.reg_val1, bus.reg_val2, bus.dbg_data);
            end
            tick();
        end
        checks++;
        if (bus.clr_busy !== 1'b0 || bus.wr_drop !== 1'b0) begin
            errors++; $display("FAIL reset_status: got busy=%b drop=%b expected 0/0", bus.clr_busy, bus.wr_drop);
        end
    endtask

    task automatic test_write_bypass();
        bus.rs = 5'd0;  bus.reg_write = 2'b01;  bus.wr_data = 32'd10; bus.dbg_addr = 5'd0;
        bus2.rs = 5'd0; bus2.reg_write = 2'b01; bus2.wr_data = 32'd10;
        #1;
        checks++;
        if (bus.reg_val1 !== 32'd10) begin
            errors++; $display("FAIL bypass_on_val1: got %0d expected 10", bus.reg_val1);
        end
        checks++;
        if (bus2.reg_val1 !== 32'd0) begin
            errors++; $display("FAIL bypass_off_val1: got %0d expected 0", bus2.reg_val1);
        end
        checks++;
        if (bus.dbg_data !== 32'd0) begin
            errors++; $display("FAIL dbg_no_bypass: got %0d expected 0", bus.dbg_data);
        end
        tick();
        bus.reg_write = 2'b00; bus2.reg_write = 2'b00;
        #1;
        checks++;
        if (bus.reg_val1 !== 32'd10 || bus2.reg_val1 !== 32'd10) begin
            errors++; $display("FAIL write_next_cycle: got %0d/%0d expected 10/10", bus.reg_val1, bus2.reg_val1);
        end
    endtask

    task automatic test_sequence();
        bus.rs = 5'd1; bus.reg_write = 2'b01; bus.wr_data = 32'd2;
        tick();
        bus.rs = 5'd0; bus.rt = 5'd1; bus.reg_write = 2'b01; bus.wr_data = 32'd12;
        #1;
        checks++;
        if (bus.reg_val2 !== 32'd2) begin
            errors++; $display("FAIL seq_read_r1: got %0d expected 2", bus.reg_val2);
        end
        checks++;
        if (bus.reg_val1 !== 32'd12) begin
            errors++; $display("FAIL seq_bypass_r0: got %0d expected 12", bus.reg_val1);
        end
        tick();
        bus.reg_write = 2'b00; bus.dbg_addr = 5'd0;
        #1;
        checks++;
        if (bus.dbg_data !== 32'd12) begin
            errors++; $display("FAIL seq_dbg_r0: got %0d expected 12", bus.dbg_data);
        end
        bus.dbg_addr = 5'd1;
        #1;
        checks++;
        if (bus.dbg_data !== 32'd2) begin
            errors++; $display("FAIL seq_dbg_r1: got %0d expected 2", bus.dbg_data);
        end
    endtask

    task automatic test_link_and_rt();
        bus.rs = 5'd3; bus.rt = 5'd3; bus.reg_write = 2'b11; bus.wr_data = 32'h40;
        #1;
        checks++;
        if (bus.reg_val1 !== 32'd0) begin
            errors++; $display("FAIL link_no_bypass_r3: got %h expected 0", bus.reg_val1);
        end
        tick();
        bus.reg_write = 2'b00; bus.dbg_addr = 5'd31;
        #1;
        checks++;
        if (bus.dbg_data !== 32'h40) begin
            errors++; $display("FAIL link_r31: got %h expected 40", bus.dbg_data);
        end
        bus.dbg_addr = 5'd3;
        #1;
        checks++;
        if (bus.dbg_data !== 32'h0) begin
            errors++; $display("FAIL link_r3_unchanged: got %h expected 0", bus.dbg_data);
        end
        bus.rs = 5'd31; bus.rt = 5'd3; bus.reg_write = 2'b11; bus.wr_data = 32'h41;
        #1;
        checks++;
        if (bus.reg_val1 !== 32'h41 || bus.reg_val2 !== 32'h0) begin
            errors++; $display("FAIL link_bypass: got %h/%h expected 41/0", bus.reg_val1, bus.reg_val2);
        end
        tick();
        bus.rs = 5'd6; bus.rt = 5'd5; bus.reg_write = 2'b10; bus.wr_data = 32'h55;
        #1;
        checks++;
        if (bus.reg_val2 !== 32'h55 || bus.reg_val1 !== 32'h0) begin
            errors++; $display("FAIL rt_write_bypass: got %h/%h expected 0/55", bus.reg_val1, bus.reg_val2);
        end
        tick();
        bus.reg_write = 2'b00; bus.dbg_addr = 5'd5;
        #1;
        checks++;
        if (bus.dbg_data !== 32'h55) begin
            errors++; $display("FAIL rt_write_r5: got %h expected 55", bus.dbg_data);
        end
        bus.dbg_addr = 5'd6;
        #1;
        checks++;
        if (bus.dbg_data !== 32'h0) begin
            errors++; $display("FAIL rt_write_r6_untouched: got %h expected 0", bus.dbg_data);
        end
    endtask

    task automatic test_clear();
        int busy_cycles;
        int drops;
        fill_main(1, 1);
        bus.dbg_addr = 5'd31;
        #1;
        checks++;
        if (bus.dbg_data !== 32'd32) begin
            errors++; $display("FAIL fill_r31: got %0d expected 32", bus.dbg_data);
        end
        // clr_req together with a write: the write lands, then the clear starts.
        bus.clr_req = 1'b1; bus.rs = 5'd0; bus.reg_write = 2'b01; bus.wr_data = 32'h99;
        #1;
        checks++;
        if (bus.clr_busy !== 1'b0) begin
            errors++; $display("FAIL clr_busy_early: got %b expected 0", bus.clr_busy);
        end
        tick();
        bus.clr_req = 1'b0;
        busy_cycles = 0;
        drops = 0;
        for (int k = 1; k <= 40; k++) begin
            bus.rs        = 5'd1;
            bus.reg_write = (k == 5) ? 2'b01 : 2'b00;
            bus.wr_data   = 32'hdead_beef;
            bus.clr_req   = (k == 8);
            bus.dbg_addr  = (k == 1) ? 5'd0 : 5'd10;
            #1;
            if (bus.wr_drop === 1'b1) drops++;
            if (k == 1) begin
                checks++;
                if (bus.dbg_data !== 32'h99) begin
                    errors++; $display("FAIL clr_simul_write: got %h expected 99", bus.dbg_data);
                end
            end
            if (k == 5) begin
                checks++;
                if (bus.reg_val1 !== 32'd0) begin
                    errors++; $display("FAIL clr_no_bypass: got %h expected 0", bus.reg_val1);
                end
                checks++;
                if (bus.dbg_data !== 32'd11) begin
                    errors++; $display("FAIL clr_r10_pending: got %0d expected 11", bus.dbg_data);
                end
            end
            if (k == 6) begin
                checks++;
                if (bus.wr_drop !== 1'b1) begin
                    errors++; $display("FAIL clr_wr_drop: got %b expected 1", bus.wr_drop);
                end
                checks++;
                if (bus.reg_val1 !== 32'd0) begin
                    errors++; $display("FAIL clr_write_discarded: got %h expected 0", bus.reg_val1);
                end
            end
            if (k == 12) begin
                checks++;
                if (bus.dbg_data !== 32'd0) begin
                    errors++; $display("FAIL clr_r10_cleared: got %0d expected 0", bus.dbg_data);
                end
            end
            if (bus.clr_busy !== 1'b1) break;
            busy_cycles++;
            tick();
        end
        bus.reg_write = 2'b00; bus.clr_req = 1'b0;
        checks++;
        if (busy_cycles != 32) begin
            errors++; $display("FAIL clr_busy_len: got %0d expected 32", busy_cycles);
        end
        checks++;
        if (drops != 1) begin
            errors++; $display("FAIL clr_drop_count: got %0d expected 1", drops);
        end
        for (int a = 0; a < 32; a++) begin
            bus.dbg_addr = 5'(a);
            #1;
            checks++;
            if (bus.dbg_data !== 32'd0) begin
                errors++; $display("FAIL clr_final a=%0d: got %h expected 0", a, bus.dbg_data);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_clear();
        fill_main(3, 7);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (10) tick();
        bus.dbg_addr = 5'd15;
        #1;
        checks++;
        if (bus.clr_busy !== 1'b1 || bus.dbg_data !== 32'd52) begin
            errors++; $display("FAIL midclr_pre: got busy=%b r15=%0d expected 1/52", bus.clr_busy, bus.dbg_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.clr_busy !== 1'b0) begin
            errors++; $display("FAIL midclr_busy_async: got %b expected 0", bus.clr_busy);
        end
        checks++;
        if (bus.dbg_data !== 32'd0) begin
            errors++; $display("FAIL midclr_r15_async: got %0d expected 0", bus.dbg_data);
        end
        tick();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.clr_busy !== 1'b0) begin
            errors++; $display("FAIL midclr_no_resume: got %b expected 0", bus.clr_busy);
        end
        for (int a = 0; a < 32; a++) begin
            bus.dbg_addr = 5'(a);
            #1;
            checks++;
            if (bus.dbg_data !== 32'd0) begin
                errors++; $display("FAIL midclr_final a=%0d: got %h expected 0", a, bus.dbg_data);
            end
            tick();
        end
    endtask

    task automatic test_range();
        bus2.rs = 5'd30; bus2.reg_write = 2'b01; bus2.wr_data = 32'h77;
        #1;
        checks++;
        if (bus2.reg_val1 !== 32'd0 || bus2.wr_drop !== 1'b0) begin
            errors++; $display("FAIL range_pre: got val=%h drop=%b expected 0/0", bus2.reg_val1, bus2.wr_drop);
        end
        tick();
        bus2.reg_write = 2'b00; bus2.dbg_addr = 5'd30;
        #1;
        checks++;
        if (bus2.wr_drop !== 1'b1) begin
            errors++; $display("FAIL range_wr_drop: got %b expected 1", bus2.wr_drop);
        end
        checks++;
        if (bus2.reg_val1 !== 32'd0 || bus2.dbg_data !== 32'd0) begin
            errors++; $display("FAIL range_read30: got %h/%h expected 0/0", bus2.reg_val1, bus2.dbg_data);
        end
        bus2.rs = 5'd23; bus2.reg_write = 2'b01; bus2.wr_data = 32'h23;
        tick();
        bus2.reg_write = 2'b00; bus2.dbg_addr = 5'd23;
        #1;
        checks++;
        if (bus2.wr_drop !== 1'b0 || bus2.dbg_data !== 32'h23) begin
            errors++; $display("FAIL range_last_reg: got drop=%b r23=%h expected 0/23", bus2.wr_drop, bus2.dbg_data);
        end
        bus2.rs = 5'd20; bus2.reg_write = 2'b11; bus2.wr_data = 32'h2020;
        #1;
        checks++;
        if (bus2.reg_val1 !== 32'd0) begin
            errors++; $display("FAIL range_link_nobyp: got %h expected 0", bus2.reg_val1);
        end
        tick();
        bus2.reg_write = 2'b00; bus2.dbg_addr = 5'd20;
        #1;
        checks++;
        if (bus2.dbg_data !== 32'h2020) begin
            errors++; $display("FAIL range_link_r20: got %h expected 2020", bus2.dbg_data);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write_bypass();
        test_sequence();
        test_link_and_rt();
        test_clear();
        test_reset_mid_clear();
        test_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
